// File: rtl/syscall_unit.sv
// syscall_unit
//   Services the SYSCALL instruction from the register file's v0/a0 taps.
//   While a call is in progress the core is stalled; console bytes leave over
//   a valid/ready stream, strings are read one byte at a time from data memory,
//   and exit codes halt the machine until reset.
//   Service codes: 1 print int, 4 print string, 10 exit, 11 print char,
//   17 exit with a0[7:0] (when ENABLE_EXIT2=1).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   isSyscall           decode flags SYSCALL (held by core while stall=1)
//   v0, a0              service code and argument taps
//   stall               freeze PC/writeback
//   memReq, memAddr     byte read request and its address
//   memValid, memData   read completion and returned byte
//   charOut, charValid  console byte stream (held until charReady)
//   charReady           console sink ready
//   halted, exitCode    sticky halt flag and exit code
//   badCall             one-cycle pulse on an unknown service code
module syscall_unit #(
  parameter int MAX_STR_LEN  = 256,
  parameter bit ENABLE_EXIT2 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isSyscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memValid,
  input  logic [7:0]  memData,
  output logic [7:0]  charOut,
  output logic        charValid,
  input  logic        charReady,
  output logic        halted,
  output logic [7:0]  exitCode,
  output logic        badCall
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHAR,
    S_INT_SIGN,
    S_INT_DIGIT,
    S_INT_EMIT,
    S_STR_REQ,
    S_STR_EMIT,
    S_DONE,
    S_BAD,
    S_HALT
  } state_t;

  state_t      state, state_d;
  logic [7:0]  ch, ch_d;
  logic [31:0] ptr, ptr_d;
  logic [7:0]  exit_q, exit_d;
  logic [31:0] mag, mag_d;
  logic [31:0] cnt, cnt_d;
  logic [3:0]  idx, idx_d;
  logic [3:0]  digit, digit_d;
  logic        started, started_d;
  logic        neg, neg_d;

  function automatic logic [31:0] pow10(input logic [3:0] i);
    case (i)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      4'd9:    pow10 = 32'd1000000000;
      default: pow10 = 32'd1;
    endcase
  endfunction

  // Two's-complement negate read back as unsigned, so -2^31 yields 2^31.
  function automatic logic [31:0] abs32(input logic signed [31:0] x);
    logic signed [31:0] n;
    n = -x;
    abs32 = x[31] ? 32'(n) : 32'(x);
  endfunction

  // Control and the architecturally visible registers are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ch     <= 8'h00;
      ptr    <= 32'h0;
      exit_q <= 8'h00;
    end else begin
      state  <= state_d;
      ch     <= ch_d;
      ptr    <= ptr_d;
      exit_q <= exit_d;
    end
  end

  // Working registers are always loaded at the trigger edge before use.
  always_ff @(posedge clk) begin
    mag     <= mag_d;
    cnt     <= cnt_d;
    idx     <= idx_d;
    digit   <= digit_d;
    started <= started_d;
    neg     <= neg_d;
  end

  always_comb begin
    state_d   = state;
    ch_d      = ch;
    ptr_d     = ptr;
    exit_d    = exit_q;
    mag_d     = mag;
    cnt_d     = cnt;
    idx_d     = idx;
    digit_d   = digit;
    started_d = started;
    neg_d     = neg;

    case (state)
      S_IDLE: begin
        if (isSyscall) begin
          case (v0)
            32'd1: begin
              mag_d     = abs32(a0);
              neg_d     = a0[31];
              ch_d      = 8'h2D;
              idx_d     = 4'd9;
              digit_d   = 4'd0;
              started_d = 1'b0;
              state_d   = S_INT_SIGN;
            end
            32'd4: begin
              ptr_d   = a0;
              cnt_d   = 32'd0;
              state_d = S_STR_REQ;
            end
            32'd11: begin
              ch_d    = a0[7:0];
              state_d = S_CHAR;
            end
            32'd10: begin
              exit_d  = 8'h00;
              state_d = S_HALT;
            end
            32'd17: begin
              if (ENABLE_EXIT2) begin
                exit_d  = a0[7:0];
                state_d = S_HALT;
              end else begin
                state_d = S_BAD;
              end
            end
            default: state_d = S_BAD;
          endcase
        end
      end
      S_CHAR: begin
        if (charReady) state_d = S_DONE;
      end
      S_INT_SIGN: begin
        // Non-negative values skip straight to the digits.
        if (!neg || charReady) state_d = S_INT_DIGIT;
      end
      S_INT_DIGIT: begin
        // Digit found by repeated subtraction, one per cycle.
        if (mag >= pow10(idx)) begin
          mag_d   = mag - pow10(idx);
          digit_d = digit + 4'd1;
        end else if (digit != 4'd0 || started || idx == 4'd0) begin
          ch_d      = 8'h30 + {4'h0, digit};
          started_d = 1'b1;
          state_d   = S_INT_EMIT;
        end else begin
          idx_d = idx - 4'd1;
        end
      end
      S_INT_EMIT: begin
        if (charReady) begin
          if (idx == 4'd0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx - 4'd1;
            digit_d = 4'd0;
            state_d = S_INT_DIGIT;
          end
        end
      end
      S_STR_REQ: begin
        if (memValid) begin
          if (memData == 8'h00) begin
            state_d = S_DONE;
          end else begin
            ch_d    = memData;
            state_d = S_STR_EMIT;
          end
        end
      end
      S_STR_EMIT: begin
        if (charReady) begin
          ptr_d = ptr + 32'd1;
          cnt_d = cnt + 32'd1;
          if (cnt + 32'd1 == 32'(MAX_STR_LEN)) state_d = S_DONE;
          else                                 state_d = S_STR_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_BAD:   state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign charOut   = ch;
  assign charValid = (state == S_CHAR) || (state == S_INT_SIGN && neg) ||
                     (state == S_INT_EMIT) || (state == S_STR_EMIT);
  assign memReq    = (state == S_STR_REQ);
  assign memAddr   = ptr;
  assign halted    = (state == S_HALT);
  assign exitCode  = exit_q;
  assign badCall   = (state == S_BAD);
  assign stall     = (state != S_IDLE && state != S_DONE && state != S_BAD) ||
                     (state == S_IDLE && isSyscall) || halted;

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        isSyscall = 1'b0;
  logic        isSyscall2 = 1'b0;
  logic [31:0] v0 = 32'h0;
  logic [31:0] a0 = 32'h0;
  logic        memValid = 1'b0, memValid2 = 1'b0;
  logic [7:0]  memData = 8'h0, memData2 = 8'h0;
  logic        charReady = 1'b1;
  logic        charReady2 = 1'b1;

  logic        stall, memReq, charValid, halted, badCall;
  logic [31:0] memAddr;
  logic [7:0]  charOut, exitCode;
  logic        stall2, memReq2, charValid2, halted2, badCall2;
  logic [31:0] memAddr2;
  logic [7:0]  charOut2, exitCode2;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp2_q[$];
  logic [7:0]  mem [logic [31:0]];
  int          nreq = 0, nreq2 = 0;
  logic [31:0] last_addr = 32'h0, last_addr2 = 32'h0;

  always #5 clk = ~clk;

  syscall_unit dut (
    .clk(clk), .reset(reset), .isSyscall(isSyscall), .v0(v0), .a0(a0),
    .stall(stall), .memReq(memReq), .memAddr(memAddr), .memValid(memValid),
    .memData(memData), .charOut(charOut), .charValid(charValid),
    .charReady(charReady), .halted(halted), .exitCode(exitCode), .badCall(badCall)
  );

  syscall_unit #(.MAX_STR_LEN(2), .ENABLE_EXIT2(1'b1)) dut2 (
    .clk(clk), .reset(reset), .isSyscall(isSyscall2), .v0(v0), .a0(a0),
    .stall(stall2), .memReq(memReq2), .memAddr(memAddr2), .memValid(memValid2),
    .memData(memData2), .charOut(charOut2), .charValid(charValid2),
    .charReady(charReady2), .halted(halted2), .exitCode(exitCode2), .badCall(badCall2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    rd = mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic push_str(input string s, input bit sel);
    for (int i = 0; i < s.len(); i++) begin
      if (sel) exp2_q.push_back(s[i]);
      else     exp_q.push_back(s[i]);
    end
  endtask

  // Memory: answers any request in the cycle it is raised.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      memValid  = 1'b0;
      memValid2 = 1'b0;
      if (memReq) begin
        memValid = 1'b1; memData = rd(memAddr); nreq++; last_addr = memAddr;
      end
      if (memReq2) begin
        memValid2 = 1'b1; memData2 = rd(memAddr2); nreq2++; last_addr2 = memAddr2;
      end
    end
  end

  // Monitor: every accepted console byte is popped and compared.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (charValid && charReady) begin
        if (exp_q.size() == 0) check("unexpected_byte", {56'h0, charOut}, 64'h100);
        else begin e = exp_q.pop_front(); check("byte", {56'h0, charOut}, {56'h0, e}); end
      end
      if (charValid2 && charReady2) begin
        if (exp2_q.size() == 0) check("unexpected_byte2", {56'h0, charOut2}, 64'h100);
        else begin e = exp2_q.pop_front(); check("byte2", {56'h0, charOut2}, {56'h0, e}); end
      end
    end
  end

  // Acts as the core: raises isSyscall and holds it while stalled.
  task automatic do_call(input bit sel, input logic [31:0] code, input logic [31:0] arg,
                         input int hold_at, output int scyc, output logic bad_end);
    logic [7:0] ref_ch;
    bit held, first;
    int guard;
    @(posedge clk); #1;
    v0 = code; a0 = arg;
    if (sel) isSyscall2 = 1'b1; else isSyscall = 1'b1;
    scyc = 0; held = 0; first = 1; bad_end = 1'b0;
    for (guard = 0; guard < 3000; guard++) begin
      #1;
      if (sel ? halted2 : halted) break;
      if (!(sel ? stall2 : stall)) break;
      scyc++;
      if (!sel && hold_at > 0 && !held && charValid && scyc >= hold_at) begin
        held = 1; charReady = 1'b0; ref_ch = charOut;
        repeat (5) begin
          @(posedge clk); #2;
          check("backpressure_hold", {52'h0, charValid, ref_ch == charOut, memReq, stall},
                {52'h0, 1'b1, 1'b1, 1'b0, 1'b1});
        end
        charReady = 1'b1;
      end
      @(posedge clk); #1;
      if (first) begin
        // Argument taps change after the trigger; the unit must ignore them.
        v0 = 32'hDEAD; a0 = ~arg; first = 0;
      end
    end
    if (guard >= 3000) check("call_timeout", 64'(guard), 64'(0));
    bad_end = sel ? badCall2 : badCall;
    isSyscall = 1'b0; isSyscall2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; isSyscall = 1'b0; isSyscall2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    outs = {11'h0, stall, memReq, charValid, halted, badCall, charOut, memAddr, exitCode};
  endfunction

  initial begin
    int sc;
    logic b;
    bit seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs(), 64'h0);

    // Print char: two stall cycles, byte taken right after trigger.
    exp_q.push_back(8'h41);
    do_call(0, 32'd11, 32'h41, 0, sc, b);
    check("char_stall_cycles", 64'(sc), 64'd2);
    check("char_no_bad", {63'h0, b}, 64'h0);
    check("char_drain", 64'(exp_q.size()), 64'h0);

    push_str("0", 0);
    do_call(0, 32'd1, 32'd0, 0, sc, b);
    check("int0_drain", 64'(exp_q.size()), 64'h0);

    push_str("-2147483648", 0);
    do_call(0, 32'd1, 32'h8000_0000, 0, sc, b);
    check("intmin_drain", 64'(exp_q.size()), 64'h0);

    push_str("305", 0);
    do_call(0, 32'd1, 32'd305, 0, sc, b);
    check("int305_drain", 64'(exp_q.size()), 64'h0);

    push_str("-7", 0);
    do_call(0, 32'd1, 32'hFFFF_FFF9, 0, sc, b);
    check("intneg7_drain", 64'(exp_q.size()), 64'h0);

    // Print string "Hi".
    mem[32'h100] = 8'h48; mem[32'h101] = 8'h69; mem[32'h102] = 8'h00;
    nreq = 0;
    push_str("Hi", 0);
    do_call(0, 32'd4, 32'h100, 0, sc, b);
    check("str_req_count", 64'(nreq), 64'd3);
    check("str_last_addr", {32'h0, last_addr}, 64'h102);
    check("str_drain", 64'(exp_q.size()), 64'h0);

    // Print string with the sink stalled mid-string.
    mem[32'h200] = 8'h48; mem[32'h201] = 8'h65; mem[32'h202] = 8'h79; mem[32'h203] = 8'h00;
    nreq = 0;
    push_str("Hey", 0);
    do_call(0, 32'd4, 32'h200, 4, sc, b);
    check("bp_req_count", 64'(nreq), 64'd4);
    check("bp_drain", 64'(exp_q.size()), 64'h0);

    // Length cap of 2 on the second instance.
    mem[32'h300] = 8'h61; mem[32'h301] = 8'h62; mem[32'h302] = 8'h63; mem[32'h303] = 8'h00;
    nreq2 = 0;
    push_str("ab", 1);
    do_call(1, 32'd4, 32'h300, 0, sc, b);
    check("cap_req_count", 64'(nreq2), 64'd2);
    check("cap_last_addr", {32'h0, last_addr2}, 64'h301);
    check("cap_drain", 64'(exp2_q.size()), 64'h0);

    // Unknown code.
    do_call(0, 32'd7, 32'd0, 0, sc, b);
    check("bad_pulse", {63'h0, b}, 64'h1);
    check("bad_stall_cycles", 64'(sc), 64'd1);
    check("bad_pulse_ends", {63'h0, badCall}, 64'h0);

    // Reset while printing an int; '-' is held and must vanish.
    charReady = 1'b0;
    @(posedge clk); #1;
    v0 = 32'd1; a0 = 32'h8000_0000; isSyscall = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #2;
      if (charValid) seen = 1;
    end
    check("midint_seen_valid", {63'h0, seen}, 64'h1);
    reset = 1'b1; isSyscall = 1'b0;
    @(posedge clk); #1;
    check("midint_reset_valid", {63'h0, charValid}, 64'h0);
    reset = 1'b0; charReady = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("midint_idle", {62'h0, stall, charValid}, 64'h0);

    // Exit code 10.
    do_call(0, 32'd10, 32'h55, 0, sc, b);
    check("exit10", {54'h0, halted, stall, exitCode}, {54'h0, 1'b1, 1'b1, 8'h00});
    do_reset();

    // Exit code 17 with a0=0x1FF.
    do_call(0, 32'd17, 32'h1FF, 0, sc, b);
    check("exit17", {54'h0, halted, stall, exitCode}, {54'h0, 1'b1, 1'b1, 8'hFF});
    repeat (3) @(posedge clk);
    #1 check("exit17_sticky", {62'h0, halted, stall}, 64'h3);
    do_reset();
    @(negedge clk);
    check("reset_after_halt", outs(), 64'h0);

    check("leftover_bytes", 64'(exp_q.size() + exp2_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
